serial_subtractor: RTL

- Bit-serial subtractor for the CPU datapath, the subtract-direction counterpart of the ripple adder used for immediate adds.
- Computes D = RS − RT − BIN one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Produces BOUT, ZERO, NEG and OVF flags with a START/BUSY/DONE handshake.
- Used by the ALU for SUB/CMP and for area-limited subtract-immediate paths.

---
 rtl/serial_subtractor.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = RS - RT - BIN, LSB first, with START/BUSY/DONE handshake and flags
module serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] RS,
   input  logic [WIDTH-1:0] RT,
   input  logic             BIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BOUT,
   output logic             ZERO,
   output logic             NEG,
   output logic             OVF
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
   logic w_q, w_d, sa_q, sa_d, sb_q, sb_d;
   logic bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
   logic acc, bit_d, bit_w, last;
   assign BUSY = st_q == RUN;
   assign DONE = st_q == FIN;
   assign D    = d_q;
   assign BOUT = bout_q;
   assign ZERO = zero_q;
   assign NEG  = neg_q;
   assign OVF  = ovf_q;
   // Full-subtractor cell, accept logic and next-state; the step after the final bit publishes the result
   always_comb begin
      acc    = START && st_q != RUN;
      bit_d  = a_q[0] ^ b_q[0] ^ w_q;
      bit_w  = (~a_q[0] & b_q[0]) | (~a_q[0] & w_q) | (b_q[0] & w_q);
      last   = cnt_q == CW'(WIDTH);
      st_d   = st_q;
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      r_d    = r_q;
      w_d    = w_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      d_d    = d_q;
      bout_d = bout_q;
      zero_d = zero_q;
      neg_d  = neg_q;
      ovf_d  = ovf_q;
      if (acc) begin
         st_d  = RUN;
         a_d   = RS;
         b_d   = RT;
         w_d   = BIN;
         cnt_d = '0;
      end else if (st_q == RUN && last) begin
         st_d   = FIN;
         d_d    = r_q;
         bout_d = w_q;
         zero_d = r_q == '0;
         neg_d  = r_q[WIDTH-1];
         ovf_d  = (sa_q != sb_q) && (r_q[WIDTH-1] != sa_q);
      end else if (st_q == RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         r_d   = {bit_d, r_q[WIDTH-1:1]};
         w_d   = bit_w;
         cnt_d = cnt_q + 1'b1;
         sa_d  = cnt_q == CW'(WIDTH - 1) ? a_q[0] : sa_q;
         sb_d  = cnt_q == CW'(WIDTH - 1) ? b_q[0] : sb_q;
      end else if (st_q == FIN) begin
         st_d = IDLE;
      end
   end
   // State, datapath and result registers with asynchronous clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         w_q    <= 1'b0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         d_q    <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         r_q    <= r_d;
         w_q    <= w_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         d_q    <= d_d;
         bout_q <= bout_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
         ovf_q  <= ovf_d;
      end
   end
endmodule
